// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory-ready handshake, wait timeout and illegal-op trap.
// Outputs are Moore decodes of state; FETCH enables and MEMWR completion follow mem_ready.
module mips_multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] Aluop,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic [1:0] err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StIdle   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StMemAdr = 4'd3,
        StMemRd  = 4'd4,
        StMemWb  = 4'd5,
        StMemWr  = 4'd6,
        StExec   = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StTrap   = 4'd15
    } state_e;

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_err;
    logic [1:0]       w_err_next;
    logic             w_mem_state;
    logic             w_timeout;

    // zero is consumed by the datapath together with PCWriteCond, not by this FSM.
    logic w_unused_zero;
    assign w_unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_err   <= 2'b00;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_err   <= w_err_next;
        end
    end

    always_comb begin
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        MemtoReg     = 1'b0;
        RegDst       = 1'b0;
        RegWrite     = 1'b0;
        AluSrcA      = 1'b0;
        AluSrcB      = 2'b00;
        Aluop        = 2'b00;
        PCSource     = 2'b00;
        instr_done   = 1'b0;
        w_state_next = r_state;
        w_err_next   = r_err;

        w_mem_state = (r_state == StFetch) || (r_state == StMemRd) || (r_state == StMemWr);
        w_timeout   = w_mem_state && !mem_ready && (r_cnt == CNT_W'(MEM_TIMEOUT - 1));

        case (r_state)
            StIdle: w_state_next = StFetch;
            StFetch: begin
                MemRead = 1'b1;
                AluSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) w_state_next = StDecode;
            end
            StDecode: begin
                AluSrcB = 2'b11;
                case (op)
                    6'b000000:           w_state_next = StExec;
                    6'b100011, 6'b101011: w_state_next = StMemAdr;
                    6'b000100:           w_state_next = StBranch;
                    6'b000010:           w_state_next = StJump;
                    default:             w_state_next = StTrap;
                endcase
            end
            StMemAdr: begin
                AluSrcA      = 1'b1;
                AluSrcB      = 2'b10;
                w_state_next = op[3] ? StMemWr : StMemRd;
            end
            StMemRd: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) w_state_next = StMemWb;
            end
            StMemWb: begin
                RegWrite     = 1'b1;
                MemtoReg     = 1'b1;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StMemWr: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                if (mem_ready) w_state_next = StFetch;
            end
            StExec: begin
                AluSrcA      = 1'b1;
                Aluop        = 2'b10;
                w_state_next = StAluWb;
            end
            StAluWb: begin
                RegWrite     = 1'b1;
                RegDst       = 1'b1;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StBranch: begin
                AluSrcA      = 1'b1;
                Aluop        = 2'b01;
                PCWriteCond  = 1'b1;
                PCSource     = 2'b01;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StJump: begin
                PCWrite      = 1'b1;
                PCSource     = 2'b10;
                instr_done   = 1'b1;
                w_state_next = StFetch;
            end
            StTrap:  w_state_next = StTrap;
            default: w_state_next = StIdle;
        endcase

        // A stalled access that runs out of budget must not complete any side effect.
        if (w_timeout) begin
            PCWrite      = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            IRWrite      = 1'b0;
            instr_done   = 1'b0;
            w_state_next = StTrap;
        end

        if ((w_state_next == StTrap) && (r_state != StTrap)) begin
            w_err_next = w_timeout ? 2'b01 : 2'b10;
        end

        if (w_state_next != r_state) begin
            w_cnt_next = '0;
        end else if (w_mem_state && !mem_ready) begin
            w_cnt_next = r_cnt + 1'b1;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    assign err   = r_err;
    assign state = r_state;

endmodule
